dma_modport: RTL and testbench
==============================

Name: dma_modport

Overview:
- Memory-mapped DMA configuration/status register block on a simple single-cycle valid/wr_en bus.
- Holds four 32-bit registers (INTR, CTRL, IO_ADDR, MEM_ADDR) at a parameterised base address.
- Serves as the register-layer (RAL) target; a bus driver writes/reads it and a monitor observes addr/wr_en/valid/wdata/rdata.

Parameters:
- BASE_ADDR, 32'h0000_0400, byte address of INTR; other registers at +4, +8, +C.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- addr  input  32  byte address of access
- wr_en  input  1  1 = write, 0 = read (qualified by valid)
- valid  input  1  access strobe, one access per cycle when high
- wdata  input  32  write data
- rdata  output  32  read data

Behaviour:
- Register map, all reset to 0:
  - BASE+0x0 INTR: [15:0] status RW, [31:16] mask RW.
  - BASE+0x4 CTRL: [0] start_dma RW, [3:1] w_count RW, [4] io_mem RW, [31:5] reserved (read 0, writes ignored).
  - BASE+0x8 IO_ADDR: [31:0] RW.
  - BASE+0xC MEM_ADDR: [31:0] RW.
- Write: at posedge clk with valid=1 and wr_en=1, the addressed register takes wdata (masked per field). The value is visible on the next cycle.
- Read: at posedge clk with valid=1 and wr_en=0, rdata is registered with the addressed register's value. Data is valid one cycle after the request edge (1-cycle latency).
- rdata holds its last value when there is no read. Writes never change rdata.
- Address decode is exact full 32-bit match. Unaligned or unmapped addresses:
  - writes are ignored, no register changes;
  - reads return 32'h0.
- Read and write to the same register on back-to-back cycles: the read returns the newly written value.
- valid=0: wr_en, addr and wdata are ignored, including X values.
- Reset (synchronous, active-high):
  - all registers and rdata go to 0 at the first posedge with reset=1;
  - reset overrides any simultaneous access;
  - registers stay 0 while reset is held.
- No wait states, no backpressure, no error response.

Test Plan:
- Reset: assert reset 2 cycles, then read all four addresses -> rdata = 0x0 each, one cycle after each read.
- Write/read each register: write 0xDEADBEEF to IO_ADDR (0x408) and 0x12345678 to MEM_ADDR (0x40C), read back -> exact values.
- Field masking: write 0xFFFFFFFF to CTRL (0x404) -> read 0x0000001F. Write 0xABCD1234 to INTR -> read 0xABCD1234.
- Unmapped/unaligned: write 0x55 to 0x410 and 0x405 -> no register changes. Reads of 0x410 and 0x405 -> 0x0.
- Hold/valid gating: toggle wr_en/addr/wdata with valid=0 -> registers unchanged and rdata holds its previous read value. Back-to-back write then read of MEM_ADDR -> new value.
- Reset mid-operation: write 0xCAFEF00D to IO_ADDR, assert reset in the same cycle as a second write -> IO_ADDR reads 0x0 after reset.

Source files
------------

// File: rtl/dma_modport_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_modport_if
//  Description : Single-cycle valid/wr_en register bus between a bus driver
//                (master) and the DMA register block (slave).
//                  addr  [31:0] byte address of the access
//                  wr_en        1 = write, 0 = read (qualified by valid)
//                  valid        access strobe, one access per cycle
//                  wdata [31:0] write data
//                  rdata [31:0] registered read data (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dma_modport_if;
  logic [31:0] addr;
  logic        wr_en;
  logic        valid;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output valid,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  valid,
    input  wdata,
    output rdata
  );
endinterface
`default_nettype wire

// File: rtl/dma_modport.sv
`default_nettype none
// ============================================================================
//  Module      : dma_modport
//  Description : DMA configuration/status register block. Four 32-bit
//                registers at BASE_ADDR:
//                  +0x0 INTR     [15:0] status, [31:16] mask
//                  +0x4 CTRL     [0] start_dma, [3:1] w_count, [4] io_mem
//                  +0x8 IO_ADDR  [31:0]
//                  +0xC MEM_ADDR [31:0]
//                Ports:
//                  clk    rising-edge clock
//                  reset  synchronous active-high reset
//                  bus    slave side of dma_modport_if
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_modport #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  wire logic      clk,
  input  wire logic      reset,
  dma_modport_if.slave   bus
);

  localparam logic [31:0] c_OFS_INTR     = 32'h0000_0000;
  localparam logic [31:0] c_OFS_CTRL     = 32'h0000_0004;
  localparam logic [31:0] c_OFS_IO_ADDR  = 32'h0000_0008;
  localparam logic [31:0] c_OFS_MEM_ADDR = 32'h0000_000C;

  logic [15:0] r_intr_status;
  logic [15:0] r_intr_mask;
  logic        r_ctrl_start;
  logic [2:0]  r_ctrl_w_count;
  logic        r_ctrl_io_mem;
  logic [31:0] r_io_addr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_rdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_sel_intr;
  logic        w_sel_ctrl;
  logic        w_sel_io;
  logic        w_sel_mem;
  logic [31:0] w_rd_value;

  // valid is the first term so X on wr_en/addr never leaks through when idle.
  assign w_wr = bus.valid && (bus.wr_en == 1'b1);
  assign w_rd = bus.valid && (bus.wr_en == 1'b0);

  // Exact full-width match: unaligned or out-of-window addresses hit nothing.
  assign w_sel_intr = (bus.addr == (BASE_ADDR + c_OFS_INTR));
  assign w_sel_ctrl = (bus.addr == (BASE_ADDR + c_OFS_CTRL));
  assign w_sel_io   = (bus.addr == (BASE_ADDR + c_OFS_IO_ADDR));
  assign w_sel_mem  = (bus.addr == (BASE_ADDR + c_OFS_MEM_ADDR));

  always_comb begin
    w_rd_value = 32'h0;
    if (w_sel_intr) begin
      w_rd_value = {r_intr_mask, r_intr_status};
    end else if (w_sel_ctrl) begin
      w_rd_value = {27'h0, r_ctrl_io_mem, r_ctrl_w_count, r_ctrl_start};
    end else if (w_sel_io) begin
      w_rd_value = r_io_addr;
    end else if (w_sel_mem) begin
      w_rd_value = r_mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_intr_status  <= 16'h0;
      r_intr_mask    <= 16'h0;
      r_ctrl_start   <= 1'b0;
      r_ctrl_w_count <= 3'h0;
      r_ctrl_io_mem  <= 1'b0;
      r_io_addr      <= 32'h0;
      r_mem_addr     <= 32'h0;
    end else if (w_wr) begin
      if (w_sel_intr) begin
        r_intr_status <= bus.wdata[15:0];
        r_intr_mask   <= bus.wdata[31:16];
      end
      if (w_sel_ctrl) begin
        r_ctrl_start   <= bus.wdata[0];
        r_ctrl_w_count <= bus.wdata[3:1];
        r_ctrl_io_mem  <= bus.wdata[4];
      end
      if (w_sel_io) begin
        r_io_addr <= bus.wdata;
      end
      if (w_sel_mem) begin
        r_mem_addr <= bus.wdata;
      end
    end
  end

  // Read data only updates on a read; writes and idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0;
    end else if (w_rd) begin
      r_rdata <= w_rd_value;
    end
  end

  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dma_modport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_modport
//  Description : Directed self-checking bench for dma_modport.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_modport;

  localparam logic [31:0] c_INTR  = 32'h0000_0400;
  localparam logic [31:0] c_CTRL  = 32'h0000_0404;
  localparam logic [31:0] c_IO    = 32'h0000_0408;
  localparam logic [31:0] c_MEM   = 32'h0000_040C;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] r_rd;
  logic [31:0] r_held;

  dma_modport_if bus ();

  dma_modport #(.BASE_ADDR(32'h0000_0400)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.wr_en = 1'b0;
    bus.addr  = a;
    @(posedge clk);
    #1;
    d = bus.rdata;
    bus.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset values of all four registers
    bus_read(c_INTR, r_rd); check("rst_intr", r_rd, 32'h0);
    bus_read(c_CTRL, r_rd); check("rst_ctrl", r_rd, 32'h0);
    bus_read(c_IO,   r_rd); check("rst_io",   r_rd, 32'h0);
    bus_read(c_MEM,  r_rd); check("rst_mem",  r_rd, 32'h0);

    // Full-width registers
    bus_write(c_IO,  32'hDEAD_BEEF);
    bus_write(c_MEM, 32'h1234_5678);
    bus_read(c_IO,  r_rd); check("io_rw",  r_rd, 32'hDEAD_BEEF);
    bus_read(c_MEM, r_rd); check("mem_rw", r_rd, 32'h1234_5678);

    // Field masking
    bus_write(c_CTRL, 32'hFFFF_FFFF);
    bus_read(c_CTRL, r_rd); check("ctrl_mask", r_rd, 32'h0000_001F);
    bus_write(c_CTRL, 32'h0000_000A);
    bus_read(c_CTRL, r_rd); check("ctrl_fields", r_rd, 32'h0000_000A);
    bus_write(c_INTR, 32'hABCD_1234);
    bus_read(c_INTR, r_rd); check("intr_rw", r_rd, 32'hABCD_1234);

    // Unmapped and unaligned accesses
    bus_write(32'h0000_0410, 32'h0000_0055);
    bus_write(32'h0000_0405, 32'h0000_0055);
    bus_write(32'h0000_0000, 32'h0000_0055);
    bus_read(32'h0000_0410, r_rd); check("rd_unmapped",  r_rd, 32'h0);
    bus_read(32'h0000_0405, r_rd); check("rd_unaligned", r_rd, 32'h0);
    bus_read(c_INTR, r_rd); check("intr_after_bad", r_rd, 32'hABCD_1234);
    bus_read(c_CTRL, r_rd); check("ctrl_after_bad", r_rd, 32'h0000_000A);
    bus_read(c_IO,   r_rd); check("io_after_bad",   r_rd, 32'hDEAD_BEEF);
    bus_read(c_MEM,  r_rd); check("mem_after_bad",  r_rd, 32'h1234_5678);

    // valid=0 gating, including X on the other inputs; rdata must hold
    bus_read(c_IO, r_held);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
      bus.wr_en = i[0];
      bus.addr  = (i == 3) ? 32'hxxxx_xxxx : c_MEM;
      bus.wdata = (i == 2) ? 32'hxxxx_xxxx : 32'h0BAD_0000 + 32'(i);
    end
    @(posedge clk);
    #1;
    check("hold_rdata", bus.rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    // A write must not disturb rdata either
    bus_write(c_INTR, 32'h0000_FFFF);
    check("write_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
    bus_read(c_MEM, r_rd); check("mem_gated", r_rd, 32'h1234_5678);
    bus_read(c_INTR, r_rd); check("intr_new", r_rd, 32'h0000_FFFF);

    // Back-to-back write then read of MEM_ADDR
    bus_write(c_MEM, 32'h8765_4321);
    bus_read(c_MEM, r_rd); check("b2b_mem", r_rd, 32'h8765_4321);

    // Reset in the same cycle as a write
    bus_write(c_IO, 32'hCAFE_F00D);
    @(negedge clk);
    reset     = 1'b1;
    bus.valid = 1'b1;
    bus.wr_en = 1'b1;
    bus.addr  = c_IO;
    bus.wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    check("rst_clears_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_read(c_IO,   r_rd); check("io_after_rst",   r_rd, 32'h0);
    bus_read(c_INTR, r_rd); check("intr_after_rst", r_rd, 32'h0);
    bus_read(c_MEM,  r_rd); check("mem_after_rst",  r_rd, 32'h0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
